// File: rtl/shift_pkg.sv
// Shared types and constants for the shift_rx serial-to-parallel receiver.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_rx_if.sv
// Serial-in / word-out bus of shift_rx. The master side feeds bits and accepts words.
interface shift_rx_if import shift_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             serial_in;
    logic             bit_valid;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output start, serial_in, bit_valid, word_ready,
        input  word_out, word_valid, busy, overrun, parity_err
    );

    modport slave (
        input  start, serial_in, bit_valid, word_ready,
        output word_out, word_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/shift_rx_hold.sv
// Output hold register for shift_rx: ready/valid handshake and sticky overrun flag.
module shift_rx_hold import shift_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             overrun
);
    logic accept;

    // A new word may enter when the register is empty or is being drained this cycle.
    assign accept = !word_valid || word_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load && accept) begin
                word_out   <= din;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (load && !accept) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/shift_rx.sv
// MSB-first serial receiver: IDLE/SHIFT FSM, bit counter and shift register.
// Optional trailing even-parity bit when SHIFT_RX_PARITY_EN is defined.
module shift_rx import shift_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    shift_rx_if.slave     bus
);
`ifdef SHIFT_RX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   done_word;
    logic               restart;
    logic               take_bit;
    logic               frame_done;
    logic               last_bit;
    logic               par_ok;

    assign last_bit = (cnt == CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        take_bit   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = SHIFT;
                    restart    = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (bus.bit_valid) begin
                    take_bit = 1'b1;
                    if (last_bit) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A start cycle that also carries a valid bit takes that bit as bit 0 of the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (restart) begin
            cnt   <= bus.bit_valid ? CNT_W'(1) : '0;
            shreg <= bus.bit_valid ? {{(WIDTH-1){1'b0}}, bus.serial_in} : '0;
        end else if (take_bit) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt < CNT_W'(WIDTH)) begin
                shreg <= {shreg[WIDTH-2:0], bus.serial_in};
            end
        end
    end

`ifdef SHIFT_RX_PARITY_EN
    logic par_acc;
    logic parity_err_q;

    // The trailing parity bit is checked, never shifted into the data word.
    assign done_word = shreg;
    assign par_ok    = !(par_acc ^ bus.serial_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_acc      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= frame_done && !par_ok;
            if (restart)       par_acc <= bus.bit_valid && bus.serial_in;
            else if (take_bit) par_acc <= par_acc ^ bus.serial_in;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign done_word      = {shreg[WIDTH-2:0], bus.serial_in};
    assign par_ok         = 1'b1;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.busy = (state == SHIFT);

    shift_rx_hold #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (frame_done && par_ok),
        .din        (done_word),
        .word_ready (bus.word_ready),
        .word_out   (bus.word_out),
        .word_valid (bus.word_valid),
        .overrun    (bus.overrun)
    );
endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 Parameter WIDTH, default 16, is the data bits per frame; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  frame-start pulse, sampled on clk; begins a new frame.
REQ-005 serial_in  input  1  serial data bit, MSB first.
REQ-006 bit_valid  input  1  qualifies serial_in; a bit is consumed only when bit_valid=1 in SHIFT.
REQ-007 word_out  output  WIDTH  received parallel word, held stable while word_valid=1.
REQ-008 word_valid  output  1  word_out holds an unconsumed word.
REQ-009 word_ready  input  1  consumer accepts word_out when word_valid=1 and word_ready=1.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 overrun  output  1  sticky flag: a completed word was dropped because the hold register was full.
REQ-012 parity_err  output  1  one-cycle pulse on parity mismatch; always 0 without the parity feature.

Function
REQ-013 The FSM SHALL have states IDLE and SHIFT.
REQ-014 In IDLE with start=1, the FSM SHALL enter SHIFT and clear the bit counter and shift register.
REQ-015 In SHIFT with bit_valid=1, the block SHALL set shreg <= {shreg[WIDTH-2:0], serial_in} and increment the counter; with bit_valid=0, it SHALL hold.
REQ-016 The first bit received SHALL land in word_out[WIDTH-1], so a frame shifted out MSB-first reproduces the original word.
REQ-017 On the cycle the last data bit is consumed (counter = WIDTH-1, bit_valid=1), the completed word SHALL pass to the hold register, and word_valid SHALL rise on the next clock edge (1-cycle latency).
REQ-018 After frame completion, the FSM SHALL return to IDLE; no further bits are consumed until the next start.
REQ-019 start=1 while in SHIFT SHALL abort the partial frame and restart at bit 0; the partial bits are discarded and no flag is set.
REQ-020 If start=1 and bit_valid=1 occur in the same cycle, the bit SHALL be taken as bit 0 of the new frame.
REQ-021 A handshake (word_valid & word_ready) SHALL clear word_valid on the next edge unless a new word completes in the same cycle; in that case the new word loads and word_valid stays 1.
REQ-022 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be dropped, word_out SHALL be unchanged, and overrun SHALL be set.
REQ-023 overrun SHALL clear only on reset.
REQ-024 busy SHALL equal (state == SHIFT).

Reset
REQ-025 Reset SHALL force: state IDLE, counter 0, shreg 0, word_out 0, word_valid 0, busy 0, overrun 0, parity_err 0.
REQ-026 Reset mid-frame SHALL discard the partial word with no output activity after release.

Configuration
REQ-027 With SHIFT_RX_PARITY_EN defined, a frame SHALL be WIDTH data bits plus one trailing even-parity bit.
REQ-028 With SHIFT_RX_PARITY_EN, the word SHALL be delivered only if the XOR of all WIDTH+1 bits is 0; otherwise the word is discarded and parity_err pulses for 1 cycle.
REQ-029 With SHIFT_RX_PARITY_EN, a parity-failed frame SHALL never set overrun.
REQ-030 Without SHIFT_RX_PARITY_EN, a frame SHALL be WIDTH bits and parity_err SHALL be tied to 0.

Structure
REQ-031 Shared package shift_pkg SHALL hold the FSM state typedef (IDLE, SHIFT) and the DEFAULT_WIDTH=16 constant.
REQ-032 The output hold register, handshake and overrun logic SHALL be one sub-module, shift_rx_hold; the FSM, counter and shreg stay in shift_rx.

Verification
REQ-033 Basic frame: start, then 16 valid bits of 0xA5C3 MSB-first, word_ready=1 -> word_out=0xA5C3 and word_valid high exactly 1 cycle, 1 cycle after the last bit.
REQ-034 Gaps: the same frame with bit_valid=0 on alternate cycles -> word_out=0xA5C3; busy high throughout the frame.
REQ-035 Overrun: word_ready=0, frame 0x1234 then frame 0xFFFF -> word_out stays 0x1234 and overrun=1; then word_ready=1 -> word_valid drops, overrun stays 1.
REQ-036 Restart: start, 7 bits, start again, then 16 bits of 0x0F0F -> word_out=0x0F0F with no flags set.
REQ-037 Reset: assert reset after 9 bits, release, then a full frame of 0x8001 -> only 0x8001 delivered, all flags 0.
REQ-038 Parity (SHIFT_RX_PARITY_EN): frame 0x0001 with parity bit 1 -> delivered; frame 0x0001 with parity bit 0 -> parity_err 1-cycle pulse, word_valid stays 0.
